// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the load/shift register sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFTING,
        FINISH
    } seq_state_t;

    localparam int SEQ_WIDTH = 32;
    localparam int SEQ_CNT_W = 6;

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter: load values above MAX clamp to MAX, decrement stops at zero.
module shift_seq_counter
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = SEQ_CNT_W,
    parameter int MAX   = SEQ_WIDTH
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    localparam logic [CNT_W-1:0] MAX_VALUE = CNT_W'(MAX);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/shift_load_sequencer.sv
// Loads a word into the downstream shift register, then shifts it left N times.
// Optional ABORT input enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_load_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic [CNT_W-1:0] IN_COUNT,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             ABORT,
`endif
    output logic             SHIFT,
    output logic [WIDTH-1:0] REG_DATA,
    output logic             BUSY,
    output logic             DONE
);

    seq_state_t       state_reg;
    logic [WIDTH-1:0] mirror_reg;
    logic [WIDTH-1:0] mirror_shifted;
    logic             shift_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             transfer;
    logic             abort_req;
    logic             last_shift;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_value;

    assign IN_READY = (state_reg == IDLE) && !RST;
    assign transfer = IN_VALID && IN_READY;
    assign cnt_dec  = (state_reg == SHIFTING);

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_req = ABORT;
`else
    assign abort_req = 1'b0;
`endif

    // The counter never sits at zero while shifting, so 1 marks the final shift.
    assign last_shift = abort_req || (cnt_value == CNT_W'(1));

    assign mirror_shifted[0] = 1'b0;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
        assign mirror_shifted[gi] = mirror_reg[gi-1];
    end

    shift_seq_counter #(
        .CNT_W (CNT_W),
        .MAX   (WIDTH)
    ) u_counter (
        .clk        (CLK),
        .srst       (RST),
        .load       (transfer),
        .load_value (IN_COUNT),
        .dec        (cnt_dec),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            mirror_reg <= '0;
            shift_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (transfer) begin
                        mirror_reg <= IN_DATA;
                        state_reg  <= LOAD;
                        shift_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cnt_zero) begin
                        state_reg <= FINISH;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= SHIFTING;
                        shift_reg <= 1'b1;
                    end
                end
                SHIFTING: begin
                    // Mirror tracks the register, which shifts on this same edge.
                    mirror_reg <= mirror_shifted;
                    if (last_shift) begin
                        state_reg <= FINISH;
                        shift_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // REG_DATA is the mirror itself so the register reloads the result while idle.
    assign REG_DATA = mirror_reg;
    assign SHIFT    = shift_reg;
    assign BUSY     = busy_reg;
    assign DONE     = done_reg;

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Self-checking bench for shift_load_sequencer; define SHIFT_SEQ_ABORT_EN to exercise ABORT.
module tb_shift_load_sequencer;

    logic        CLK;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_count;
    logic        shift;
    logic [31:0] reg_data;
    logic        busy;
    logic        done;
`ifdef SHIFT_SEQ_ABORT_EN
    logic        abort;
`endif

    shift_load_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK      (CLK),
        .RST      (rst),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .IN_DATA  (in_data),
        .IN_COUNT (in_count),
`ifdef SHIFT_SEQ_ABORT_EN
        .ABORT    (abort),
`endif
        .SHIFT    (shift),
        .REG_DATA (reg_data),
        .BUSY     (busy),
        .DONE     (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: one sequence described by its transfer edge, data and effective count.
    int          cyc = 0;
    bit          have_seq = 0;
    int          t_x = 0;
    int          n_eff = 0;
    logic [31:0] data_x = '0;
    logic [31:0] result = '0;
    int          xfer_count = 0;
    logic [31:0] ds_reg = '0;
    int          last_done_cyc = -1;
    int          dut_xfers[$];
    bit          rand_abort = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return !rst && (!have_seq || (cyc - t_x >= n_eff + 2));
    endfunction

    task automatic tick();
        bit          xfer;
        logic        pre_shift;
        logic [31:0] pre_reg;
        int          d;
        int          k;
        xfer      = in_valid && model_ready();
        pre_shift = shift;
        pre_reg   = reg_data;
        if (in_valid && in_ready === 1'b1) dut_xfers.push_back(cyc + 1);
`ifdef SHIFT_SEQ_ABORT_EN
        d = cyc - t_x;
        if (!rst && have_seq && abort && d >= 1 && d <= n_eff) begin
            n_eff  = d;
            result = data_x << d;
        end
`endif
        @(posedge CLK);
        #1;
        cyc++;
        // Downstream register driven by the DUT's pins.
        if (rst) ds_reg = '0;
        else if (pre_shift) ds_reg = ds_reg << 1;
        else ds_reg = pre_reg;
        if (rst) begin
            have_seq = 0;
        end else if (xfer) begin
            have_seq = 1;
            t_x      = cyc;
            data_x   = in_data;
            n_eff    = (int'(in_count) > 32) ? 32 : int'(in_count);
            result   = in_data << n_eff;
            xfer_count++;
        end
        if (done === 1'b1) last_done_cyc = cyc;
        d = cyc - t_x;
        check("in_ready", 32'(in_ready), 32'(model_ready()));
        if (!have_seq) begin
            check("shift_idle", 32'(shift), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
            check("done_idle", 32'(done), 32'd0);
            check("reg_data_rst", reg_data, 32'd0);
            check("ds_reg_rst", ds_reg, 32'd0);
        end else begin
            check("shift", 32'(shift), 32'(d >= 1 && d <= n_eff));
            check("busy", 32'(busy), 32'(d <= n_eff));
            check("done", 32'(done), 32'(d == n_eff + 1));
            if (d == 0) check("reg_data_load", reg_data, data_x);
            else if (d >= n_eff + 1) check("reg_data_result", reg_data, result);
            if (d >= 1) begin
                k = (d - 1 < n_eff) ? d - 1 : n_eff;
                check("ds_reg", ds_reg, data_x << k);
            end
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] c);
        int start;
        int k;
        start    = xfer_count;
        in_valid = 1'b1;
        in_data  = d;
        in_count = c;
        k = 0;
        while (xfer_count == start && k < 80) begin
            tick();
            k++;
        end
        if (xfer_count == start) begin
            errors++;
            $display("FAIL send_timeout observed no transfer expected transfer within 80 cycles");
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        in_count = 6'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (have_seq && (cyc - t_x < n_eff + 2) && k < 80) begin
`ifdef SHIFT_SEQ_ABORT_EN
            abort = rand_abort && ($urandom_range(0, 7) == 0);
`endif
            tick();
            k++;
        end
`ifdef SHIFT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        if (k >= 80) begin
            errors++;
            $display("FAIL idle_timeout observed busy expected idle within 80 cycles");
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_count = '0;
`ifdef SHIFT_SEQ_ABORT_EN
        abort    = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Count 1: DONE two edges after the transfer, result held while idle.
        send(32'hF000_0001, 6'd1);
        wait_idle();
        check("done_lat_n1", 32'(last_done_cyc - t_x), 32'd2);
        repeat (3) tick();
        check("hold_e0000002", reg_data, 32'hE000_0002);

        // Count 0: straight from LOAD to FINISH.
        send(32'hF000_0001, 6'd0);
        wait_idle();
        check("done_lat_n0", 32'(last_done_cyc - t_x), 32'd1);
        check("result_n0", reg_data, 32'hF000_0001);

        // Count 40 saturates at 32 shifts.
        send(32'h8000_0001, 6'd40);
        wait_idle();
        check("done_lat_n40", 32'(last_done_cyc - t_x), 32'd33);
        check("result_n40", reg_data, 32'h0000_0000);

        // Continuous valid: transfers spaced N+3 edges apart.
        dut_xfers.delete();
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        in_count = 6'd4;
        repeat (16) tick();
        in_valid = 1'b0;
        wait_idle();
        if (dut_xfers.size() >= 2) begin
            check("b2b_spacing", 32'(dut_xfers[1] - dut_xfers[0]), 32'd7);
        end else begin
            errors++;
            $display("FAIL b2b_count observed %0d expected 2 or more transfers", dut_xfers.size());
        end

        // Reset during the 3rd shift cycle of a count-8 sequence.
        last_done_cyc = -1;
        send(32'hF000_0001, 6'd8);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        check("no_done_after_rst", 32'(last_done_cyc), 32'hFFFF_FFFF);

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort in the 3rd shift cycle: three shifts complete.
        send(32'hF000_0001, 6'd8);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle();
        check("abort_result", reg_data, 32'h8000_0008);
        check("abort_done_lat", 32'(last_done_cyc - t_x), 32'd4);
        rand_abort = 1;
`endif

        // Randomized sequences, sometimes offered while the previous one is still running.
        for (int i = 0; i < 25; i++) begin
            send($urandom, 6'($urandom_range(0, 63)));
            repeat ($urandom_range(0, 40)) tick();
        end
        wait_idle();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
